// File: rtl/sw_debounce.sv
// sw_debounce: synchronise and debounce slide switches against a shared slow tick,
// publishing the clean vector, per-bit edge pulses and an all-zero flag.
module sw_debounce #(
    parameter int WIDTH        = 16,
    parameter int TICK_DIV     = 100000,
    parameter int STABLE_TICKS = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_clean,
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall,
    output logic             sw_change,
    output logic             sw_all_zero
);
    localparam int TW = $clog2(TICK_DIV);
    localparam int CW = STABLE_TICKS > 1 ? $clog2(STABLE_TICKS) : 1;

    logic [WIDTH-1:0]         s1, s2, accept, clean_nxt;
    logic [TW-1:0]            tcnt;
    logic                     tick;
    logic [WIDTH-1:0][CW-1:0] cnt;

    assign tick      = tcnt == TW'(TICK_DIV - 1);
    assign clean_nxt = sw_clean ^ accept;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1   <= '0;
            s2   <= '0;
            tcnt <= '0;
        end else begin
            s1   <= sw_raw;
            s2   <= s1;
            tcnt <= tick ? '0 : tcnt + 1'b1;
        end
    end

    // A bit flips only on the tick that completes its run of mismatching ticks
    always_comb begin
        for (int i = 0; i < WIDTH; i++)
            accept[i] = tick && s2[i] != sw_clean[i] && cnt[i] == CW'(STABLE_TICKS - 1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else begin
            for (int i = 0; i < WIDTH; i++)
                cnt[i] <= (s2[i] == sw_clean[i] || accept[i]) ? '0 : tick ? cnt[i] + 1'b1 : cnt[i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sw_clean    <= '0;
            sw_rise     <= '0;
            sw_fall     <= '0;
            sw_change   <= 1'b0;
            sw_all_zero <= 1'b1;
        end else begin
            sw_clean    <= clean_nxt;
            sw_rise     <= accept & s2;
            sw_fall     <= accept & ~s2;
            sw_change   <= |accept;
            sw_all_zero <= clean_nxt == '0;
        end
    end
endmodule

// File: tb/tb_sw_debounce.sv
// tb_sw_debounce: table vectors, hand-written corner sequences and random stimulus
// checked every cycle against a time-based model of the debounce rules.
module tb_sw_debounce;
    localparam int TD = 4;
    localparam int ST = 3;

    logic        clk, rst;
    logic [15:0] sw_raw, sw_clean, sw_rise, sw_fall;
    logic        sw_change, sw_all_zero;

    int vectors = 0;
    int miscompares = 0;

    sw_debounce #(.WIDTH(16), .TICK_DIV(TD), .STABLE_TICKS(ST)) dut (
        .clk(clk), .rst(rst), .sw_raw(sw_raw), .sw_clean(sw_clean), .sw_rise(sw_rise),
        .sw_fall(sw_fall), .sw_change(sw_change), .sw_all_zero(sw_all_zero)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    // Model: a bit is accepted on a tick if it has disagreed with the clean value
    // continuously since at least (ST-1) tick periods before that tick.
    logic [15:0] m_s1, m_s2, m_clean, m_rise, m_fall;
    logic        m_change, m_zero;
    int          cyc;
    int          run_start [16];

    task automatic model_reset();
        m_s1 = 0; m_s2 = 0; m_clean = 0; m_rise = 0; m_fall = 0;
        m_change = 0; m_zero = 1; cyc = 0;
        for (int i = 0; i < 16; i++) run_start[i] = -1;
    endtask

    task automatic model_step();
        logic [15:0] acc;
        acc = 0;
        for (int i = 0; i < 16; i++) begin
            if (m_s2[i] == m_clean[i]) run_start[i] = -1;
            else if (run_start[i] < 0) run_start[i] = cyc;
            if (run_start[i] >= 0 && cyc % TD == TD - 1 && run_start[i] <= cyc - (ST - 1) * TD) begin
                acc[i] = 1;
                run_start[i] = -1;
            end
        end
        m_rise = acc & m_s2;
        m_fall = acc & ~m_s2;
        m_change = |acc;
        m_clean = m_clean ^ acc;
        m_zero = m_clean == 0;
        m_s2 = m_s1;
        m_s1 = sw_raw;
        cyc++;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s (cycle %0d): got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic step(input logic [15:0] raw);
        sw_raw = raw;
        model_step();
        @(posedge clk);
        #1;
        check("outputs", {29'd0, sw_clean, sw_rise, sw_fall, sw_change, sw_all_zero},
              {29'd0, m_clean, m_rise, m_fall, m_change, m_zero});
    endtask

    task automatic run(input logic [15:0] raw, input int n, input logic [15:0] tgt,
                       output int first, output int nchg, output int nrise, output int nfall,
                       output logic [15:0] rise_or, output logic [15:0] fall_or);
        first = -1; nchg = 0; nrise = 0; nfall = 0; rise_or = 0; fall_or = 0;
        for (int k = 1; k <= n; k++) begin
            step(raw);
            if (first < 0 && sw_clean == tgt) first = k;
            nchg += int'(sw_change);
            nrise += int'(sw_rise != 0);
            nfall += int'(sw_fall != 0);
            rise_or |= sw_rise;
            fall_or |= sw_fall;
        end
    endtask

    typedef struct {
        logic [15:0] raw;
        int          n;
        logic [15:0] exp;
    } vec_t;

    vec_t        tbl [9];
    int          first, nchg, nrise, nfall, bc, hold;
    logic [15:0] rise_or, fall_or, r;

    initial begin
        tbl[0] = '{16'h0000, 14, 16'h0000};
        tbl[1] = '{16'h00A5, 14, 16'h00A5};
        tbl[2] = '{16'h5A00, 2, 16'h00A5};
        tbl[3] = '{16'h00A5, 14, 16'h00A5};
        tbl[4] = '{16'h1234, 10, 16'h00A5};
        tbl[5] = '{16'h1234, 14, 16'h1234};
        tbl[6] = '{16'hFF00, 14, 16'hFF00};
        tbl[7] = '{16'h0000, 5, 16'hFF00};
        tbl[8] = '{16'h0000, 14, 16'h0000};

        // Reset state and re-debounce of switches already high
        rst = 1;
        sw_raw = 16'hFFFF;
        #12;
        check("reset_clean", 64'(sw_clean), 64'h0);
        check("reset_zero", 64'(sw_all_zero), 64'h1);
        check("reset_edges", {29'd0, sw_rise, sw_fall, sw_change, 2'b00}, 64'h0);
        #5 rst = 0;
        model_reset();
        run(16'hFFFF, 20, 16'hFFFF, first, nchg, nrise, nfall, rise_or, fall_or);
        check("reset_latency", 64'(first), 64'd12);
        check("reset_change", 64'(nchg), 64'd1);
        check("reset_rise_cycles", 64'(nrise), 64'd1);
        check("reset_rise_mask", 64'(rise_or), 64'hFFFF);

        for (int i = 0; i < 9; i++) begin
            run(tbl[i].raw, tbl[i].n, tbl[i].exp, first, nchg, nrise, nfall, rise_or, fall_or);
            check("table_clean", 64'(sw_clean), 64'(tbl[i].exp));
        end

        // Clean single change on bit 5
        run(16'h0020, 20, 16'h0020, first, nchg, nrise, nfall, rise_or, fall_or);
        check("single_window", 64'(first >= 8 && first <= 14), 64'd1);
        check("single_change", 64'(nchg), 64'd1);
        check("single_rise_cycles", 64'(nrise), 64'd1);
        check("single_rise_mask", 64'(rise_or), 64'h0020);

        // Bounce on bit 0, toggling every 3 cycles
        bc = 0;
        for (int k = 0; k < 40; k++) begin
            step(16'h0020 | 16'((k / 3) % 2));
            bc += int'(sw_change);
        end
        run(16'h0020, 14, 16'h0020, first, nchg, nrise, nfall, rise_or, fall_or);
        check("bounce_change", 64'(bc + nchg), 64'd0);
        check("bounce_clean", 64'(sw_clean), 64'h0020);

        // Falling edge back to all-zero
        run(16'h0000, 20, 16'h0000, first, nchg, nrise, nfall, rise_or, fall_or);
        check("fall_window", 64'(first >= 8 && first <= 14), 64'd1);
        check("fall_cycles", 64'(nfall), 64'd1);
        check("fall_mask", 64'(fall_or), 64'h0020);
        check("fall_change", 64'(nchg), 64'd1);
        check("fall_zero", 64'(sw_all_zero), 64'd1);

        // Two bits changing together
        run(16'h8001, 20, 16'h8001, first, nchg, nrise, nfall, rise_or, fall_or);
        check("simul_window", 64'(first >= 8 && first <= 14), 64'd1);
        check("simul_rise_cycles", 64'(nrise), 64'd1);
        check("simul_rise_mask", 64'(rise_or), 64'h8001);
        check("simul_change", 64'(nchg), 64'd1);

        // Async reset while bit 3 is pending
        run(16'h8009, 9, 16'h8009, first, nchg, nrise, nfall, rise_or, fall_or);
        check("pend_not_yet", 64'(first), 64'hFFFF_FFFF_FFFF_FFFF);
        #2 rst = 1;
        #1;
        check("async_clean", 64'(sw_clean), 64'h0);
        check("async_zero", 64'(sw_all_zero), 64'h1);
        check("async_edges", {29'd0, sw_rise, sw_fall, sw_change, 2'b00}, 64'h0);
        #4 rst = 0;
        model_reset();
        run(16'h8009, 20, 16'h8009, first, nchg, nrise, nfall, rise_or, fall_or);
        check("async_relatency", 64'(first), 64'd12);
        check("async_change", 64'(nchg), 64'd1);
        check("async_rise_mask", 64'(rise_or), 64'h8009);

        // Random holds and glitches
        r = 16'h8009;
        for (int k = 0; k < 60; k++) begin
            hold = $urandom_range(1, 16);
            r = r ^ (16'($urandom) & 16'($urandom));
            for (int j = 0; j < hold; j++) step(r);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
